// File: rtl/debug_tx_arbiter.sv
// Purpose : round-robin share of the debug UART TX between N_REQ frame producers; sends opcode then payload, LSB byte first.
// Latency : req -> ack 1 cycle, ack -> first tx_start 1 cycle, tx_done -> next tx_start 2 cycles, FIN -> next ack 2 cycles.
// Backpressure: holds in SEND while tx_busy is high; req is sampled only in IDLE and must be held until ack.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req/req_opcode/req_len/req_data   per-requester frame request and contents (slot i at i*W)
//   flush                  synchronous abort of the frame in flight
//   ack, done              one-hot one-cycle pulses: frame latched / last byte sent
//   busy                   frame in flight, high from the ack cycle through the done cycle
//   tx_start, tx_byte      byte hand-off to the UART shifter (tx_byte held until the next start)
//   tx_busy, tx_done       UART shifter status
module debug_tx_arbiter #(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*8-1:0]          req_opcode,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                        flush,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_byte,
  input  logic                        tx_busy,
  input  logic                        tx_done
);

  localparam int MAX_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(MAX_BYTES + 1);
  localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      win_q, win_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [N_REQ-1:0]      done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_byte_q, tx_byte_d;

  // Round-robin pick: rotate req so the pointer slot sits at bit 0, take the
  // lowest set bit, then rotate the index back.
  logic [N_REQ-1:0]     req_rot;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [LEN_WIDTH-1:0] len_sel;
  logic [IDX_W-1:0]     eff_len;
  logic [7:0]           cur_byte;

  always_comb begin
    req_rot   = N_REQ'({req, req} >> rr_ptr_q);
    grant_vld = |req;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  // Lengths beyond the payload register are clipped; the surplus is silently dropped.
  always_comb begin
    len_sel = req_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
    eff_len = (int'(len_sel) > MAX_BYTES) ? IDX_W'(MAX_BYTES) : IDX_W'(len_sel);
  end

  // Payload is consumed by shifting right, so the next payload byte is always in [7:0].
  always_comb begin
    cur_byte = (idx_q == '0) ? opcode_q : data_q[7:0];
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    idx_d      = idx_q;
    len_d      = len_q;
    opcode_d   = opcode_q;
    data_d     = data_q;
    ack_d      = '0;
    done_d     = '0;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;

    if (flush && (state_q != S_IDLE)) begin
      // Abort: no done, pointer untouched so the same requester order resumes.
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // busy was left high through the done cycle; it drops here unless a new frame starts.
          busy_d = 1'b0;
          if (grant_vld) begin
            state_d          = S_SEND;
            win_d            = grant_idx;
            idx_d            = '0;
            len_d            = eff_len;
            opcode_d         = req_opcode[int'(grant_idx)*8 +: 8];
            data_d           = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            ack_d[grant_idx] = 1'b1;
            busy_d           = 1'b1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_byte_d  = cur_byte;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (idx_q == len_q) begin
              state_d = S_FIN;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SEND;
              // Index 0 was the opcode; only advance the payload after a payload byte.
              if (idx_q != '0) begin
                data_d = data_q >> 8;
              end
            end
          end
        end
        S_FIN: begin
          done_d[win_q] = 1'b1;
          state_d       = S_IDLE;
          rr_ptr_d      = (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      opcode_q   <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;

endmodule
